// File: rtl/keyboard_action_scheduler.sv
// PS/2 make/break decoder feeding a held-key map, and a rate-limited
// round-robin scheduler that turns held keys into one-cycle gamepad key codes.
module keyboard_action_scheduler #(
    parameter int unsigned MOVE_PERIOD    = 500000,
    parameter int unsigned SHOOT_COOLDOWN = 5000000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_scan_code,
    input  logic       i_scan_valid,
    input  logic       i_game_active,
    output logic [7:0] o_key,
    output logic       o_key_valid,
    output logic [3:0] o_held,
    output logic       o_shoot_ready
);

    typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXT_BRK} pstate_t;
    typedef enum logic {A_IDLE, A_GAP} astate_t;
    typedef enum logic [1:0] {RR_SHOOT, RR_GADGET, RR_MOVE} rr_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [7:0] KEY_SHOOT  = 8'h1D;
    localparam logic [7:0] KEY_GADGET = 8'h1B;
    localparam logic [7:0] KEY_LEFT   = 8'h1C;
    localparam logic [7:0] KEY_RIGHT  = 8'h23;
    localparam logic [CNT_W-1:0] MOVE_RELOAD = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(SHOOT_COOLDOWN - 1);

    pstate_t          pstate_q, pstate_d;
    astate_t          astate_q, astate_d;
    rr_t              rr_q, rr_d;
    dir_t             dir_q, dir_d;
    logic [3:0]       held_q, held_d;
    logic             shoot_pend_q, shoot_pend_d;
    logic             gadget_pend_q, gadget_pend_d;
    logic             move_pend_q, move_pend_d;
    logic [CNT_W-1:0] move_tmr_q, move_tmr_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic [7:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;

    logic       is_make, is_break, ext_byte;
    logic [3:0] key_mask;
    logic       up_make, down_make;
    logic       grant_s, grant_g, grant_m;
    logic       elig_s;
    dir_t       dir_new;

    // Held-map bit for a key byte: {up, down, left, right}.
    function automatic logic [3:0] map_key(input logic [7:0] code, input logic ext);
        logic [3:0] m;
        m = '0;
        if (ext) begin
            case (code)
                8'h75:   m = 4'b1000;
                8'h72:   m = 4'b0100;
                8'h6B:   m = 4'b0010;
                8'h74:   m = 4'b0001;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h1D:   m = 4'b1000;
                8'h1B:   m = 4'b0100;
                8'h1C:   m = 4'b0010;
                8'h23:   m = 4'b0001;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    function automatic dir_t dir_of(input logic [3:0] held);
        dir_t d;
        d = DIR_NONE;
        if (held[1] && !held[0]) d = DIR_LEFT;
        else if (held[0] && !held[1]) d = DIR_RIGHT;
        return d;
    endfunction

    always_comb begin
        pstate_d = pstate_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext_byte = 1'b0;
        if (i_scan_valid) begin
            pstate_d = P_IDLE;
            case (pstate_q)
                P_IDLE: begin
                    if (i_scan_code == 8'hF0)      pstate_d = P_BRK;
                    else if (i_scan_code == 8'hE0) pstate_d = P_EXT;
                    else                           is_make  = 1'b1;
                end
                P_BRK: begin
                    if (i_scan_code == 8'hE0) pstate_d = P_EXT_BRK;
                    else                      is_break = 1'b1;
                end
                P_EXT: begin
                    ext_byte = 1'b1;
                    if (i_scan_code == 8'hF0) pstate_d = P_EXT_BRK;
                    else                      is_make  = 1'b1;
                end
                default: begin
                    ext_byte = 1'b1;
                    is_break = 1'b1;
                end
            endcase
        end
        key_mask = map_key(i_scan_code, ext_byte);
        held_d   = held_q;
        if (is_make)  held_d = held_q | key_mask;
        if (is_break) held_d = held_q & ~key_mask;
        up_make   = is_make && key_mask[3] && !held_q[3];
        down_make = is_make && key_mask[2] && !held_q[2];
    end

    always_comb begin
        astate_d = astate_q;
        rr_d     = rr_q;
        key_d    = '0;
        grant_s  = 1'b0;
        grant_g  = 1'b0;
        grant_m  = 1'b0;
        elig_s   = shoot_pend_q && (cool_q == '0);
        if (!i_game_active) begin
            astate_d = A_IDLE;
        end else if (astate_q == A_GAP) begin
            astate_d = A_IDLE;
        end else begin
            case (rr_q)
                RR_SHOOT: begin
                    if (elig_s)             grant_s = 1'b1;
                    else if (gadget_pend_q) grant_g = 1'b1;
                    else if (move_pend_q)   grant_m = 1'b1;
                end
                RR_GADGET: begin
                    if (gadget_pend_q)    grant_g = 1'b1;
                    else if (move_pend_q) grant_m = 1'b1;
                    else if (elig_s)      grant_s = 1'b1;
                end
                default: begin
                    if (move_pend_q)        grant_m = 1'b1;
                    else if (elig_s)        grant_s = 1'b1;
                    else if (gadget_pend_q) grant_g = 1'b1;
                end
            endcase
            if (grant_s) begin
                key_d = KEY_SHOOT;
                rr_d  = RR_GADGET;
            end else if (grant_g) begin
                key_d = KEY_GADGET;
                rr_d  = RR_MOVE;
            end else if (grant_m) begin
                key_d = (dir_q == DIR_LEFT) ? KEY_LEFT : KEY_RIGHT;
                rr_d  = RR_SHOOT;
            end
            if (grant_s || grant_g || grant_m) astate_d = A_GAP;
        end
        key_valid_d = (key_d != 8'h00);
    end

    // Direction follows the next held map so a fresh step costs no extra cycle;
    // forcing NONE while inactive makes re-activation count as a new transition.
    always_comb begin
        dir_new       = i_game_active ? dir_of(held_d) : DIR_NONE;
        dir_d         = dir_new;
        shoot_pend_d  = i_game_active && ((shoot_pend_q && !grant_s) || up_make);
        gadget_pend_d = i_game_active && ((gadget_pend_q && !grant_g) || down_make);
        move_pend_d   = move_pend_q && !grant_m;
        move_tmr_d    = move_tmr_q;
        if (dir_new == DIR_NONE) begin
            move_pend_d = 1'b0;
            move_tmr_d  = '0;
        end else if (dir_new != dir_q || move_tmr_q == '0) begin
            move_pend_d = 1'b1;
            move_tmr_d  = MOVE_RELOAD;
        end else begin
            move_tmr_d = move_tmr_q - CNT_W'(1);
        end
        cool_d = cool_q;
        if (grant_s)              cool_d = COOL_RELOAD;
        else if (cool_q != '0)    cool_d = cool_q - CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pstate_q      <= P_IDLE;
            astate_q      <= A_IDLE;
            rr_q          <= RR_SHOOT;
            dir_q         <= DIR_NONE;
            held_q        <= '0;
            shoot_pend_q  <= 1'b0;
            gadget_pend_q <= 1'b0;
            move_pend_q   <= 1'b0;
            move_tmr_q    <= '0;
            cool_q        <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
        end else begin
            pstate_q      <= pstate_d;
            astate_q      <= astate_d;
            rr_q          <= rr_d;
            dir_q         <= dir_d;
            held_q        <= held_d;
            shoot_pend_q  <= shoot_pend_d;
            gadget_pend_q <= gadget_pend_d;
            move_pend_q   <= move_pend_d;
            move_tmr_q    <= move_tmr_d;
            cool_q        <= cool_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
        end
    end

    assign o_key         = key_q;
    assign o_key_valid   = key_valid_q;
    assign o_held        = held_q;
    assign o_shoot_ready = (cool_q == '0);

endmodule

// File: tb/tb_keyboard_action_scheduler.sv
// Directed-vector bench for keyboard_action_scheduler with short move and
// cooldown periods so repeat and cooldown timing can be checked cycle by cycle.
module tb_keyboard_action_scheduler;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_scan_code;
    logic       i_scan_valid;
    logic       i_game_active;
    logic [7:0] o_key;
    logic       o_key_valid;
    logic [3:0] o_held;
    logic       o_shoot_ready;

    int checks;
    int failures;

    keyboard_action_scheduler #(
        .MOVE_PERIOD(8),
        .SHOOT_COOLDOWN(20),
        .CNT_W(24)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_scan_code(i_scan_code),
        .i_scan_valid(i_scan_valid),
        .i_game_active(i_game_active),
        .o_key(o_key),
        .o_key_valid(o_key_valid),
        .o_held(o_held),
        .o_shoot_ready(o_shoot_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One clock edge; the byte (if v) is sampled on that edge, outputs read 1 ns later.
    task automatic step(input logic v, input logic [7:0] code);
        i_scan_valid = v;
        i_scan_code  = code;
        @(posedge i_clk);
        #1;
        i_scan_valid = 1'b0;
        i_scan_code  = 8'h00;
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_game_active = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_key !== 8'h00 || o_key_valid !== 1'b0 || o_held !== 4'b0000 || o_shoot_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: key=%h valid=%b held=%b ready=%b, expected key=00 valid=0 held=0000 ready=1",
                     o_key, o_key_valid, o_held, o_shoot_ready);
        end
    endtask

    task automatic test_shoot_press();
        do_reset();
        step(1'b1, 8'h1D);
        checks++;
        if (o_held !== 4'b1000 || o_key !== 8'h00) begin
            failures++;
            $display("FAIL shoot_make_held: held=%b key=%h, expected 1000 / 00", o_held, o_key);
        end
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h1D || o_key_valid !== 1'b1) begin
            failures++;
            $display("FAIL shoot_latency: key=%h valid=%b, expected 1D / 1", o_key, o_key_valid);
        end
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h00 || o_key_valid !== 1'b0) begin
            failures++;
            $display("FAIL shoot_one_cycle: key=%h valid=%b, expected 00 / 0", o_key, o_key_valid);
        end
        for (int t = 0; t < 30; t++) begin
            step((t == 2 || t == 5), 8'h1D);
            checks++;
            if (o_key !== 8'h00) begin
                failures++;
                $display("FAIL shoot_typematic t=%0d: key=%h, expected 00", t, o_key);
            end
        end
        step(1'b1, 8'hF0);
        step(1'b1, 8'h1D);
        checks++;
        if (o_held !== 4'b0000) begin
            failures++;
            $display("FAIL shoot_break: held=%b, expected 0000", o_held);
        end
    endtask

    task automatic test_move_repeat();
        logic [7:0] exp;
        do_reset();
        step(1'b1, 8'hE0);
        step(1'b1, 8'h6B);
        checks++;
        if (o_held !== 4'b0010) begin
            failures++;
            $display("FAIL ext_left_held: held=%b, expected 0010", o_held);
        end
        for (int t = 1; t <= 28; t++) begin
            step(1'b0, 8'h00);
            exp = (t == 1 || t == 9 || t == 17 || t == 25) ? 8'h1C : 8'h00;
            checks++;
            if (o_key !== exp || o_key_valid !== (exp != 8'h00)) begin
                failures++;
                $display("FAIL move_repeat t=%0d: key=%h valid=%b, expected %h", t, o_key, o_key_valid, exp);
            end
        end
        step(1'b1, 8'hE0);
        step(1'b1, 8'hF0);
        step(1'b1, 8'h6B);
        checks++;
        if (o_held !== 4'b0000) begin
            failures++;
            $display("FAIL ext_left_break: held=%b, expected 0000", o_held);
        end
        for (int t = 0; t < 12; t++) begin
            step((t == 1 || t == 2), (t == 1) ? 8'hF0 : 8'h1C);
            checks++;
            if (o_key !== 8'h00) begin
                failures++;
                $display("FAIL move_stopped t=%0d: key=%h, expected 00", t, o_key);
            end
        end
        checks++;
        if (o_held !== 4'b0000) begin
            failures++;
            $display("FAIL break_unheld_left: held=%b, expected 0000", o_held);
        end
    endtask

    task automatic test_cooldown();
        logic [7:0] exp;
        logic       v;
        logic [7:0] code;
        do_reset();
        step(1'b1, 8'h1D);
        for (int t = 1; t <= 24; t++) begin
            v    = (t == 2 || t == 3 || t == 6);
            code = (t == 2) ? 8'hF0 : 8'h1D;
            step(v, code);
            exp = (t == 1 || t == 21) ? 8'h1D : 8'h00;
            checks++;
            if (o_key !== exp) begin
                failures++;
                $display("FAIL cooldown_key t=%0d: key=%h, expected %h", t, o_key, exp);
            end
            checks++;
            if (o_shoot_ready !== (t == 20)) begin
                failures++;
                $display("FAIL cooldown_ready t=%0d: ready=%b, expected %b", t, o_shoot_ready, (t == 20));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_key [0:8];
        logic [7:0] stim    [0:2];
        exp_key = '{8'h00, 8'h1D, 8'h00, 8'h1B, 8'h00, 8'h23, 8'h00, 8'h00, 8'h00};
        stim    = '{8'h1D, 8'h1B, 8'h23};
        do_reset();
        for (int t = 0; t <= 8; t++) begin
            step((t <= 2), (t <= 2) ? stim[t] : 8'h00);
            checks++;
            if (o_key !== exp_key[t] || o_key_valid !== (exp_key[t] != 8'h00)) begin
                failures++;
                $display("FAIL back_to_back t=%0d: key=%h valid=%b, expected %h", t, o_key, o_key_valid, exp_key[t]);
            end
        end
    endtask

    task automatic test_both_dirs();
        do_reset();
        i_game_active = 1'b0;
        step(1'b1, 8'h1C);
        step(1'b1, 8'h23);
        checks++;
        if (o_held !== 4'b0011) begin
            failures++;
            $display("FAIL both_held: held=%b, expected 0011", o_held);
        end
        i_game_active = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 8'h00);
            checks++;
            if (o_key !== 8'h00) begin
                failures++;
                $display("FAIL both_no_move t=%0d: key=%h, expected 00", t, o_key);
            end
        end
        step(1'b1, 8'hF0);
        step(1'b1, 8'h23);
        checks++;
        if (o_held !== 4'b0010 || o_key !== 8'h00) begin
            failures++;
            $display("FAIL release_right: held=%b key=%h, expected 0010 / 00", o_held, o_key);
        end
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h1C) begin
            failures++;
            $display("FAIL left_after_release: key=%h, expected 1C", o_key);
        end
    endtask

    task automatic test_inactive_and_reset();
        do_reset();
        step(1'b1, 8'h1B);
        i_game_active = 1'b0;
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h00 || o_key_valid !== 1'b0) begin
            failures++;
            $display("FAIL inactive_blocks_gadget: key=%h valid=%b, expected 00 / 0", o_key, o_key_valid);
        end
        step(1'b1, 8'h23);
        checks++;
        if (o_held !== 4'b0101) begin
            failures++;
            $display("FAIL inactive_held_tracks: held=%b, expected 0101", o_held);
        end
        for (int t = 0; t < 5; t++) begin
            step(1'b0, 8'h00);
            checks++;
            if (o_key !== 8'h00) begin
                failures++;
                $display("FAIL inactive_quiet t=%0d: key=%h, expected 00", t, o_key);
            end
        end
        i_game_active = 1'b1;
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h00) begin
            failures++;
            $display("FAIL reactivate_edge: key=%h, expected 00", o_key);
        end
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h23) begin
            failures++;
            $display("FAIL reactivate_step: key=%h, expected 23", o_key);
        end
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 8'h00);
            checks++;
            if (o_key === 8'h1B) begin
                failures++;
                $display("FAIL gadget_dropped t=%0d: key=%h, expected not 1B", t, o_key);
            end
        end
        step(1'b1, 8'hF0);
        i_rst = 1'b1;
        step(1'b0, 8'h00);
        i_rst = 1'b0;
        checks++;
        if (o_held !== 4'b0000 || o_key !== 8'h00 || o_shoot_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_prefix_reset: held=%b key=%h ready=%b, expected 0000 / 00 / 1", o_held, o_key, o_shoot_ready);
        end
        step(1'b1, 8'h1D);
        checks++;
        if (o_held !== 4'b1000) begin
            failures++;
            $display("FAIL make_after_reset: held=%b, expected 1000", o_held);
        end
        step(1'b0, 8'h00);
        checks++;
        if (o_key !== 8'h1D) begin
            failures++;
            $display("FAIL shoot_after_reset: key=%h, expected 1D", o_key);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        i_rst         = 1'b1;
        i_scan_code   = 8'h00;
        i_scan_valid  = 1'b0;
        i_game_active = 1'b1;
        test_reset();
        test_shoot_press();
        test_move_repeat();
        test_cooldown();
        test_back_to_back();
        test_both_dirs();
        test_inactive_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
